// File: rtl/proj_pkg.sv
// Shared types and sizing for the GFM collector: frame struct, FSM state enum and part count.
package proj_pkg;

  localparam int FRAG_LEN_BITS        = 64;
  localparam int FRAG_PART            = 16;
  localparam int SIGNED_INDICE_LEN    = 8;
  localparam int FIFO_DEPTH           = 4;
  localparam int GFM_FRAG_PARTS_COUNT = FRAG_LEN_BITS / FRAG_PART;

  typedef struct packed {
    logic signed [SIGNED_INDICE_LEN-1:0] idx;
    logic [FRAG_LEN_BITS-1:0]            gfm;
  } gfm_frame_t;

  typedef enum logic {S_IDLE, S_COLLECT} gfm_coll_state_t;

endpackage

// File: rtl/proj_gfm_fifo.sv
// Synchronous frame FIFO with head output taken from storage registers (zero while empty).
module proj_gfm_fifo
  import proj_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  gfm_frame_t push_data,
  input  logic       pop,
  output gfm_frame_t head,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int PW = $clog2(DEPTH);

  gfm_frame_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/proj_gfm_collector.sv
// Reassembles extender parts into full GFM frames and queues them for a valid/ready consumer.
// Optional macro PROJ_GFM_COLLECTOR_STATS_EN adds saturating popped/dropped frame counters.
module proj_gfm_collector
  import proj_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic signed [SIGNED_INDICE_LEN-1:0] in_index,
  input  logic [FRAG_PART-1:0]                in_part,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [SIGNED_INDICE_LEN-1:0] out_index,
  output logic [FRAG_LEN_BITS-1:0]            out_gfm,
  output logic                                out_overflow,
  output logic                                out_idx_err
`ifdef PROJ_GFM_COLLECTOR_STATS_EN
  ,
  output logic [15:0]                         out_frame_cnt,
  output logic [15:0]                         out_drop_cnt
`endif
);

  localparam int CNT_W = (GFM_FRAG_PARTS_COUNT > 1) ? $clog2(GFM_FRAG_PARTS_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GFM_FRAG_PARTS_COUNT - 1);

  gfm_coll_state_t                     state;
  logic [CNT_W-1:0]                    cnt;
  logic signed [SIGNED_INDICE_LEN-1:0] idx_q;
  logic [FRAG_LEN_BITS-1:0]            asm_q;
  logic                                push;
  gfm_frame_t                          push_frame;
  gfm_frame_t                          head;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic                                drop;

  // The final part is merged combinationally so the frame is written on the same edge.
  always_comb begin
    push           = 1'b0;
    push_frame.idx = idx_q;
    push_frame.gfm = asm_q;
    push_frame.gfm[(GFM_FRAG_PARTS_COUNT-1)*FRAG_PART +: FRAG_PART] = in_part;
    if (GFM_FRAG_PARTS_COUNT == 1) begin
      push           = in_valid;
      push_frame.idx = in_index;
    end else begin
      push = in_valid && (state == S_COLLECT) && (cnt == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      out_overflow <= 1'b0;
      out_idx_err  <= 1'b0;
    end else begin
      if (drop) out_overflow <= 1'b1;
      if (in_valid && GFM_FRAG_PARTS_COUNT > 1) begin
        case (state)
          S_IDLE: begin
            idx_q                  <= in_index;
            asm_q[FRAG_PART-1:0]   <= in_part;
            cnt                    <= CNT_W'(1);
            state                  <= S_COLLECT;
          end
          S_COLLECT: begin
            if (in_index != idx_q) out_idx_err <= 1'b1;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              asm_q[cnt*FRAG_PART +: FRAG_PART] <= in_part;
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  proj_gfm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_frame),
    .pop       (out_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (drop)
  );

  assign out_valid = !fifo_empty;
  assign out_index = head.idx;
  assign out_gfm   = head.gfm;

`ifdef PROJ_GFM_COLLECTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_frame_cnt <= '0;
      out_drop_cnt  <= '0;
    end else begin
      if (out_valid && out_ready && out_frame_cnt != 16'hFFFF) out_frame_cnt <= out_frame_cnt + 16'd1;
      if (drop && out_drop_cnt != 16'hFFFF) out_drop_cnt <= out_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_proj_gfm_collector.sv
// Scoreboard bench for proj_gfm_collector: directed frames queue expectations, a monitor checks pops.
module tb_proj_gfm_collector;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [7:0]  in_index;
  logic [15:0]        in_part;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_index;
  logic [63:0]        out_gfm;
  logic               out_overflow;
  logic               out_idx_err;
`ifdef PROJ_GFM_COLLECTOR_STATS_EN
  logic [15:0]        out_frame_cnt;
  logic [15:0]        out_drop_cnt;
`endif

  typedef struct {
    logic signed [7:0] idx;
    logic [63:0]       gfm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  proj_gfm_collector dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_index     (in_index),
    .in_part      (in_part),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_gfm      (out_gfm),
    .out_overflow (out_overflow),
    .out_idx_err  (out_idx_err)
`ifdef PROJ_GFM_COLLECTOR_STATS_EN
    ,
    .out_frame_cnt(out_frame_cnt),
    .out_drop_cnt (out_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every accepted head frame must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_frame: got idx %0d gfm %h, expected none", out_index, out_gfm);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("frame_idx", 64'(out_index), 64'(e.idx));
        checkOutput("frame_gfm", out_gfm, e.gfm);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [7:0] idx, input logic [15:0] part);
    in_valid = 1'b1;
    in_index = idx;
    in_part  = part;
    step();
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic signed [7:0] idx, input logic [63:0] frame, input int gap,
                           input bit expect_out, input bit ready_on_last);
    exp_t e;
    e.idx = idx;
    e.gfm = frame;
    if (expect_out) sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && ready_on_last) out_ready = 1'b1;
      applyStimulus(idx, frame[k*16 +: 16]);
      if (k < 3) repeat (gap) step();
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int cycles;
    cycles    = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && cycles < 40) begin
      step();
      cycles++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d frames pending, expected 0", sb.size());
      sb.delete();
    end
    checkOutput("drained_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_index  = '0;
    in_part   = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    doReset();

    checkOutput("reset_valid",    64'(out_valid), 64'd0);
    checkOutput("reset_index",    64'(out_index), 64'd0);
    checkOutput("reset_gfm",      out_gfm, 64'd0);
    checkOutput("reset_overflow", 64'(out_overflow), 64'd0);
    checkOutput("reset_idx_err",  64'(out_idx_err), 64'd0);

    // Basic frame with one-cycle latency to the head
    out_ready = 1'b1;
    sendFrame(8'sd5, 64'h4444_3333_2222_1111, 0, 1'b1, 1'b0);
    checkOutput("basic_latency", 64'(out_valid), 64'd1);
    drain();

    // Gaps of three idle cycles between parts
    sb.push_back('{idx: 8'sd5, gfm: 64'h4444_3333_2222_1111});
    applyStimulus(8'sd5, 16'h1111); repeat (3) step();
    applyStimulus(8'sd5, 16'h2222); repeat (3) step();
    applyStimulus(8'sd5, 16'h3333); repeat (3) step();
    checkOutput("gaps_no_early", 64'(out_valid), 64'd0);
    applyStimulus(8'sd5, 16'h4444);
    checkOutput("gaps_latency", 64'(out_valid), 64'd1);
    drain();

    // Backpressure: four held, fifth dropped
    doReset();
    out_ready = 1'b0;
    sendFrame(8'sd1,  64'h0A03_0A02_0A01_0A00, 0, 1'b1, 1'b0);
    sendFrame(8'sd2,  64'h0B03_0B02_0B01_0B00, 2, 1'b1, 1'b0);
    sendFrame(-8'sd3, 64'h0C03_0C02_0C01_0C00, 0, 1'b1, 1'b0);
    sendFrame(8'sd4,  64'h0D03_0D02_0D01_0D00, 1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_stable", out_gfm, 64'h0A03_0A02_0A01_0A00);
      step();
    end
    checkOutput("bp_no_overflow_yet", 64'(out_overflow), 64'd0);
    sendFrame(8'sd6, 64'h0E03_0E02_0E01_0E00, 0, 1'b0, 1'b0);
    checkOutput("bp_overflow", 64'(out_overflow), 64'd1);
    checkOutput("bp_head_kept", out_gfm, 64'h0A03_0A02_0A01_0A00);
`ifdef PROJ_GFM_COLLECTOR_STATS_EN
    checkOutput("bp_drop_cnt", 64'(out_drop_cnt), 64'd1);
`endif
    drain();

    // Full FIFO with push and pop on the same edge
    doReset();
    out_ready = 1'b0;
    sendFrame(8'sd10, 64'h1003_1002_1001_1000, 0, 1'b1, 1'b0);
    sendFrame(8'sd11, 64'h1103_1102_1101_1100, 0, 1'b1, 1'b0);
    sendFrame(8'sd12, 64'h1203_1202_1201_1200, 0, 1'b1, 1'b0);
    sendFrame(8'sd13, 64'h1303_1302_1301_1300, 0, 1'b1, 1'b0);
    sendFrame(8'sd14, 64'h1403_1402_1401_1400, 0, 1'b1, 1'b1);
    checkOutput("fullpp_no_overflow", 64'(out_overflow), 64'd0);
    drain();
    checkOutput("fullpp_overflow_end", 64'(out_overflow), 64'd0);

    // Index change inside a frame
    doReset();
    out_ready = 1'b1;
    sb.push_back('{idx: 8'sd3, gfm: 64'hDDDD_CCCC_BBBB_AAAA});
    applyStimulus(8'sd3,  16'hAAAA);
    applyStimulus(8'sd3,  16'hBBBB);
    applyStimulus(-8'sd2, 16'hCCCC);
    applyStimulus(-8'sd2, 16'hDDDD);
    checkOutput("idx_err_set", 64'(out_idx_err), 64'd1);
    drain();

    // Reset mid-frame discards the partial frame
    doReset();
    out_ready = 1'b1;
    applyStimulus(8'sd7, 16'h7777);
    applyStimulus(8'sd7, 16'h8888);
    doReset();
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    sendFrame(-8'sd9, 64'h5555_6666_7777_8888, 0, 1'b1, 1'b0);
    drain();
    checkOutput("midrst_overflow", 64'(out_overflow), 64'd0);
    checkOutput("midrst_idx_err",  64'(out_idx_err), 64'd0);
`ifdef PROJ_GFM_COLLECTOR_STATS_EN
    checkOutput("midrst_frame_cnt", 64'(out_frame_cnt), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
